// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the cache interface (0) and
// the line-crypto block (1): one transaction in flight, guarded by a watchdog.
module mem_port_arbiter #(
   parameter int ADDRESS_BITS   = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int MSG_BITS       = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [MSG_BITS-1:0]   req0_msg,
   input  logic [ADDRESS_BITS:0] req0_address,
   input  logic [DATA_WIDTH-1:0] req0_data,
   input  logic [MSG_BITS-1:0]   req1_msg,
   input  logic [ADDRESS_BITS:0] req1_address,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic [MSG_BITS-1:0]   resp0_msg,
   output logic [ADDRESS_BITS:0] resp0_address,
   output logic [DATA_WIDTH-1:0] resp0_data,
   output logic [MSG_BITS-1:0]   resp1_msg,
   output logic [ADDRESS_BITS:0] resp1_address,
   output logic [DATA_WIDTH-1:0] resp1_data,
   output logic [MSG_BITS-1:0]   mem_msg,
   output logic [ADDRESS_BITS:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [MSG_BITS-1:0]   mem_resp_msg,
   input  logic [ADDRESS_BITS:0] mem_resp_address,
   input  logic [DATA_WIDTH-1:0] mem_resp_data,
   output logic                  busy,
   output logic                  owner,
   output logic                  timeout_flag
);

   localparam int WD_BITS = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_BITS-1:0]  WD_LIMIT   = WD_BITS'(TIMEOUT_CYCLES);
   localparam logic [MSG_BITS-1:0] REQ_READ   = MSG_BITS'(1);
   localparam logic [MSG_BITS-1:0] REQ_WRITE  = MSG_BITS'(2);
   localparam logic [MSG_BITS-1:0] RESP_ERROR = MSG_BITS'(3);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t state_reg, state_next;
   logic   rr_ptr_reg, rr_ptr_next;
   logic   owner_reg, owner_next;
   logic   busy_reg, busy_next;
   logic   flag_reg, flag_next;
   logic   grant_sel;
   logic [WD_BITS-1:0] wd_reg, wd_next, wd_inc;

   logic [MSG_BITS-1:0]   mem_msg_reg, mem_msg_next;
   logic [ADDRESS_BITS:0] mem_addr_reg, mem_addr_next;
   logic [DATA_WIDTH-1:0] mem_data_reg, mem_data_next;

   logic [1:0][MSG_BITS-1:0]   resp_msg_reg, resp_msg_next;
   logic [1:0][ADDRESS_BITS:0] resp_addr_reg, resp_addr_next;
   logic [1:0][DATA_WIDTH-1:0] resp_data_reg, resp_data_next;

   logic [1:0][MSG_BITS-1:0]   req_msg;
   logic [1:0][ADDRESS_BITS:0] req_addr;
   logic [1:0][DATA_WIDTH-1:0] req_data;
   logic [1:0]                 req_valid;

   assign req_msg  = {req1_msg, req0_msg};
   assign req_addr = {req1_address, req0_address};
   assign req_data = {req1_data, req0_data};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         // Reserved command encodings count as no request.
         assign req_valid[gi] = (req_msg[gi] == REQ_READ) || (req_msg[gi] == REQ_WRITE);
      end
   endgenerate

   assign wd_inc = (wd_reg == WD_LIMIT) ? wd_reg : wd_reg + WD_BITS'(1);

   always_comb begin
      state_next     = state_reg;
      rr_ptr_next    = rr_ptr_reg;
      owner_next     = owner_reg;
      busy_next      = busy_reg;
      flag_next      = flag_reg;
      wd_next        = wd_reg;
      mem_msg_next   = mem_msg_reg;
      mem_addr_next  = mem_addr_reg;
      mem_data_next  = mem_data_reg;
      resp_msg_next  = resp_msg_reg;
      resp_addr_next = resp_addr_reg;
      resp_data_next = resp_data_reg;
      grant_sel      = (req_valid == 2'b11) ? rr_ptr_reg : req_valid[1];

      case (state_reg)
         IDLE: begin
            if (mem_resp_msg != '0) flag_next = 1'b1;
            if (req_valid != 2'b00) begin
               owner_next    = grant_sel;
               mem_msg_next  = req_msg[grant_sel];
               mem_addr_next = req_addr[grant_sel];
               mem_data_next = req_data[grant_sel];
               busy_next     = 1'b1;
               wd_next       = '0;
               state_next    = BUSY;
            end
         end
         BUSY: begin
            wd_next = wd_inc;
            // A response arriving on the timeout edge still wins.
            if (mem_resp_msg != '0) begin
               resp_msg_next[owner_reg]  = mem_resp_msg;
               resp_addr_next[owner_reg] = mem_resp_address;
               resp_data_next[owner_reg] = mem_resp_data;
               mem_msg_next  = '0;
               mem_addr_next = '0;
               mem_data_next = '0;
               busy_next     = 1'b0;
               state_next    = RELEASE;
            end else if (wd_inc == WD_LIMIT) begin
               resp_msg_next[owner_reg]  = RESP_ERROR;
               resp_addr_next[owner_reg] = mem_addr_reg;
               resp_data_next[owner_reg] = '0;
               mem_msg_next  = '0;
               mem_addr_next = '0;
               mem_data_next = '0;
               busy_next     = 1'b0;
               flag_next     = 1'b1;
               state_next    = RELEASE;
            end
         end
         RELEASE: begin
            // Requests are ignored here so the owner's held msg cannot re-grant.
            if (mem_resp_msg != '0) flag_next = 1'b1;
            resp_msg_next  = '0;
            resp_addr_next = '0;
            resp_data_next = '0;
            rr_ptr_next    = ~owner_reg;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= 1'b0;
         owner_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         flag_reg      <= 1'b0;
         wd_reg        <= '0;
         mem_msg_reg   <= '0;
         mem_addr_reg  <= '0;
         mem_data_reg  <= '0;
         resp_msg_reg  <= '0;
         resp_addr_reg <= '0;
         resp_data_reg <= '0;
      end else begin
         state_reg     <= state_next;
         rr_ptr_reg    <= rr_ptr_next;
         owner_reg     <= owner_next;
         busy_reg      <= busy_next;
         flag_reg      <= flag_next;
         wd_reg        <= wd_next;
         mem_msg_reg   <= mem_msg_next;
         mem_addr_reg  <= mem_addr_next;
         mem_data_reg  <= mem_data_next;
         resp_msg_reg  <= resp_msg_next;
         resp_addr_reg <= resp_addr_next;
         resp_data_reg <= resp_data_next;
      end
   end

   assign resp0_msg     = resp_msg_reg[0];
   assign resp0_address = resp_addr_reg[0];
   assign resp0_data    = resp_data_reg[0];
   assign resp1_msg     = resp_msg_reg[1];
   assign resp1_address = resp_addr_reg[1];
   assign resp1_data    = resp_data_reg[1];
   assign mem_msg       = mem_msg_reg;
   assign mem_address   = mem_addr_reg;
   assign mem_data      = mem_data_reg;
   assign busy          = busy_reg;
   assign owner         = owner_reg;
   assign timeout_flag  = flag_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants, round-robin, watchdog, stray replies, reset.
module tb_mem_port_arbiter;

   logic        clock, reset;
   logic [2:0]  req0_msg, req1_msg, resp0_msg, resp1_msg, mem_msg, mem_resp_msg;
   logic [12:0] req0_address, req1_address, resp0_address, resp1_address;
   logic [12:0] mem_address, mem_resp_address;
   logic [31:0] req0_data, req1_data, resp0_data, resp1_data, mem_data, mem_resp_data;
   logic        busy, owner, timeout_flag;

   int tests_run    = 0;
   int tests_failed = 0;

   mem_port_arbiter #(
      .ADDRESS_BITS(12), .DATA_WIDTH(32), .MSG_BITS(3), .TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock), .reset(reset),
      .req0_msg(req0_msg), .req0_address(req0_address), .req0_data(req0_data),
      .req1_msg(req1_msg), .req1_address(req1_address), .req1_data(req1_data),
      .resp0_msg(resp0_msg), .resp0_address(resp0_address), .resp0_data(resp0_data),
      .resp1_msg(resp1_msg), .resp1_address(resp1_address), .resp1_data(resp1_data),
      .mem_msg(mem_msg), .mem_address(mem_address), .mem_data(mem_data),
      .mem_resp_msg(mem_resp_msg), .mem_resp_address(mem_resp_address),
      .mem_resp_data(mem_resp_data),
      .busy(busy), .owner(owner), .timeout_flag(timeout_flag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req0_msg = '0; req0_address = '0; req0_data = '0;
      req1_msg = '0; req1_address = '0; req1_data = '0;
      mem_resp_msg = '0; mem_resp_address = '0; mem_resp_data = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
      tests_run++; if (owner !== 1'b0) begin tests_failed++; $display("FAIL reset_owner: got %0b want 0", owner); end
      tests_run++; if (timeout_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_flag: got %0b want 0", timeout_flag); end
      tests_run++; if (mem_msg !== 3'd0 || resp0_msg !== 3'd0 || resp1_msg !== 3'd0) begin
         tests_failed++; $display("FAIL reset_msgs: mem %0d resp0 %0d resp1 %0d want 0 0 0", mem_msg, resp0_msg, resp1_msg);
      end
      $display("[TB] txn reset done");
   endtask

   task automatic test_single_read();
      req0_msg = 3'd1; req0_address = 13'h010;
      tick(); // grant
      tests_run++; if (mem_msg !== 3'd1 || mem_address !== 13'h010) begin
         tests_failed++; $display("FAIL single_grant: mem_msg %0d addr %h want 1 010", mem_msg, mem_address);
      end
      tests_run++; if (busy !== 1'b1 || owner !== 1'b0) begin
         tests_failed++; $display("FAIL single_busy_owner: busy %0b owner %0b want 1 0", busy, owner);
      end
      tick();
      tick();
      tests_run++; if (mem_msg !== 3'd1) begin tests_failed++; $display("FAIL single_mem_hold: got %0d want 1", mem_msg); end
      mem_resp_msg = 3'd2; mem_resp_address = 13'h010; mem_resp_data = 32'hDEADBEEF;
      tick(); // response edge
      mem_resp_msg = '0; mem_resp_address = '0; mem_resp_data = '0;
      req0_msg = '0;
      tests_run++; if (resp0_msg !== 3'd2 || resp0_data !== 32'hDEADBEEF) begin
         tests_failed++; $display("FAIL single_resp0: msg %0d data %h want 2 deadbeef", resp0_msg, resp0_data);
      end
      tests_run++; if (resp1_msg !== 3'd0 || mem_msg !== 3'd0 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL single_after_resp: resp1 %0d mem %0d busy %0b want 0 0 0", resp1_msg, mem_msg, busy);
      end
      tick();
      tests_run++; if (resp0_msg !== 3'd0) begin tests_failed++; $display("FAIL single_resp_one_cycle: got %0d want 0", resp0_msg); end
      tick();
      $display("[TB] txn single read 0x010 -> %h", 32'hDEADBEEF);
   endtask

   task automatic test_tie_after_reset();
      do_reset();
      req0_msg = 3'd2; req0_address = 13'h020; req0_data = 32'h12345678;
      req1_msg = 3'd1; req1_address = 13'h030;
      tick(); // grant N
      tests_run++; if (owner !== 1'b0 || mem_msg !== 3'd2 || mem_data !== 32'h12345678) begin
         tests_failed++; $display("FAIL tie_first: owner %0b msg %0d data %h want 0 2 12345678", owner, mem_msg, mem_data);
      end
      mem_resp_msg = 3'd1; mem_resp_address = 13'h020;
      tick(); // response M
      mem_resp_msg = '0; mem_resp_address = '0;
      req0_msg = '0;
      tests_run++; if (resp0_msg !== 3'd1 || resp1_msg !== 3'd0) begin
         tests_failed++; $display("FAIL tie_write_done: resp0 %0d resp1 %0d want 1 0", resp0_msg, resp1_msg);
      end
      tick(); // M+1, release
      tests_run++; if (busy !== 1'b0 || mem_msg !== 3'd0) begin
         tests_failed++; $display("FAIL tie_no_early_grant: busy %0b mem_msg %0d want 0 0", busy, mem_msg);
      end
      tick(); // M+2, grant req1
      tests_run++; if (owner !== 1'b1 || busy !== 1'b1 || mem_msg !== 3'd1 || mem_address !== 13'h030) begin
         tests_failed++; $display("FAIL tie_second: owner %0b busy %0b msg %0d addr %h want 1 1 1 030", owner, busy, mem_msg, mem_address);
      end
      mem_resp_msg = 3'd2; mem_resp_address = 13'h030; mem_resp_data = 32'hCAFEF00D;
      tick();
      mem_resp_msg = '0; mem_resp_address = '0; mem_resp_data = '0;
      req1_msg = '0;
      tests_run++; if (resp1_msg !== 3'd2 || resp1_data !== 32'hCAFEF00D || resp0_msg !== 3'd0) begin
         tests_failed++; $display("FAIL tie_resp1: resp1 %0d data %h resp0 %0d want 2 cafef00d 0", resp1_msg, resp1_data, resp0_msg);
      end
      tick();
      tick();
      $display("[TB] txn tie: owner 0 then 1");
   endtask

   task automatic test_back_to_back();
      logic       exp_owner;
      logic [2:0] got_msg, other_msg;
      logic [31:0] got_data;
      req0_msg = 3'd1; req0_address = 13'h100;
      req1_msg = 3'd1; req1_address = 13'h200;
      for (int t = 0; t < 6; t++) begin
         exp_owner = t[0];
         tick(); // grant
         tests_run++; if (busy !== 1'b1 || owner !== exp_owner) begin
            tests_failed++; $display("FAIL b2b_grant_%0d: busy %0b owner %0b want 1 %0b", t, busy, owner, exp_owner);
         end
         mem_resp_msg = 3'd2; mem_resp_address = mem_address; mem_resp_data = 32'hA0000000 + 32'(t);
         tick(); // response
         mem_resp_msg = '0; mem_resp_address = '0; mem_resp_data = '0;
         got_msg   = exp_owner ? resp1_msg : resp0_msg;
         got_data  = exp_owner ? resp1_data : resp0_data;
         other_msg = exp_owner ? resp0_msg : resp1_msg;
         tests_run++; if (got_msg !== 3'd2 || got_data !== 32'hA0000000 + 32'(t) || other_msg !== 3'd0) begin
            tests_failed++; $display("FAIL b2b_resp_%0d: msg %0d data %h other %0d want 2 %h 0", t, got_msg, got_data, other_msg, 32'hA0000000 + 32'(t));
         end
         if (exp_owner) req1_msg = '0; else req0_msg = '0;
         tick(); // release
         if (exp_owner) req1_msg = 3'd1; else req0_msg = 3'd1;
         $display("[TB] txn b2b %0d owner %0b", t, exp_owner);
      end
      req0_msg = '0; req1_msg = '0;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      req1_msg = 3'd1; req1_address = 13'h1FFF;
      tick(); // grant N
      tests_run++; if (owner !== 1'b1 || mem_address !== 13'h1FFF) begin
         tests_failed++; $display("FAIL to_grant: owner %0b addr %h want 1 1fff", owner, mem_address);
      end
      for (int k = 1; k < 8; k++) begin
         tick();
         tests_run++; if (busy !== 1'b1 || resp1_msg !== 3'd0 || timeout_flag !== 1'b0) begin
            tests_failed++; $display("FAIL to_wait_%0d: busy %0b resp1 %0d flag %0b want 1 0 0", k, busy, resp1_msg, timeout_flag);
         end
      end
      tick(); // N+8
      tests_run++; if (resp1_msg !== 3'd3 || resp1_address !== 13'h1FFF || resp1_data !== 32'h0) begin
         tests_failed++; $display("FAIL to_error: msg %0d addr %h data %h want 3 1fff 0", resp1_msg, resp1_address, resp1_data);
      end
      tests_run++; if (timeout_flag !== 1'b1 || mem_msg !== 3'd0 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL to_state: flag %0b mem_msg %0d busy %0b want 1 0 0", timeout_flag, mem_msg, busy);
      end
      req1_msg = '0;
      tick(); // release -> idle
      mem_resp_msg = 3'd2; mem_resp_address = 13'h1FFF; mem_resp_data = 32'h11111111;
      tick(); // late reply sampled in idle
      mem_resp_msg = '0; mem_resp_address = '0; mem_resp_data = '0;
      tests_run++; if (resp0_msg !== 3'd0 || resp1_msg !== 3'd0 || busy !== 1'b0 || timeout_flag !== 1'b1) begin
         tests_failed++; $display("FAIL to_late_reply: resp0 %0d resp1 %0d busy %0b flag %0b want 0 0 0 1", resp0_msg, resp1_msg, busy, timeout_flag);
      end
      tick();
      $display("[TB] txn timeout on req1 0x1fff");
   endtask

   task automatic test_stray_idle();
      do_reset();
      mem_resp_msg = 3'd1;
      tick();
      mem_resp_msg = '0;
      tests_run++; if (timeout_flag !== 1'b1 || resp0_msg !== 3'd0 || resp1_msg !== 3'd0 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL stray_idle: flag %0b resp0 %0d resp1 %0d busy %0b want 1 0 0 0", timeout_flag, resp0_msg, resp1_msg, busy);
      end
      $display("[TB] txn stray response in idle");
   endtask

   task automatic test_resp_at_timeout();
      do_reset();
      req0_msg = 3'd1; req0_address = 13'h055;
      tick(); // grant N
      repeat (7) tick();
      mem_resp_msg = 3'd2; mem_resp_address = 13'h055; mem_resp_data = 32'h5A5A5A5A;
      tick(); // N+8, coincides with watchdog limit
      mem_resp_msg = '0; mem_resp_address = '0; mem_resp_data = '0;
      req0_msg = '0;
      tests_run++; if (resp0_msg !== 3'd2 || resp0_data !== 32'h5A5A5A5A || timeout_flag !== 1'b0) begin
         tests_failed++; $display("FAIL resp_at_timeout: msg %0d data %h flag %0b want 2 5a5a5a5a 0", resp0_msg, resp0_data, timeout_flag);
      end
      tick();
      tick();
      $display("[TB] txn response on timeout edge");
   endtask

   task automatic test_reset_mid_busy();
      req1_msg = 3'd1; req1_address = 13'h0AA;
      tick(); // grant
      tests_run++; if (owner !== 1'b1 || busy !== 1'b1) begin
         tests_failed++; $display("FAIL midrst_grant: owner %0b busy %0b want 1 1", owner, busy);
      end
      #2 reset = 1'b0;
      #1;
      tests_run++; if (busy !== 1'b0 || owner !== 1'b0 || mem_msg !== 3'd0 || mem_address !== 13'h0) begin
         tests_failed++; $display("FAIL midrst_async: busy %0b owner %0b mem_msg %0d addr %h want 0 0 0 0", busy, owner, mem_msg, mem_address);
      end
      #1 reset = 1'b1;
      tick(); // pending req1 granted again
      tests_run++; if (owner !== 1'b1 || busy !== 1'b1 || mem_msg !== 3'd1 || mem_address !== 13'h0AA) begin
         tests_failed++; $display("FAIL midrst_regrant: owner %0b busy %0b msg %0d addr %h want 1 1 1 0aa", owner, busy, mem_msg, mem_address);
      end
      mem_resp_msg = 3'd2; mem_resp_address = 13'h0AA; mem_resp_data = 32'h00000077;
      tick();
      mem_resp_msg = '0; mem_resp_address = '0; mem_resp_data = '0;
      req1_msg = '0;
      tests_run++; if (resp1_msg !== 3'd2 || resp1_data !== 32'h00000077) begin
         tests_failed++; $display("FAIL midrst_resp: msg %0d data %h want 2 00000077", resp1_msg, resp1_data);
      end
      tick();
      tick();
      $display("[TB] txn reset mid-busy then req1 regrant");
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie_after_reset();
      test_back_to_back();
      test_timeout();
      test_stray_idle();
      test_resp_at_timeout();
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
